arm_mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the instruction-fetch path and the data-memory path of the 5-stage ARM pipeline. Each side issues a request with a hold-until-valid handshake. The arbiter serializes accesses through a fixed-latency memory, returns read data with a one-cycle valid pulse, and drives per-side stall signals that the pipeline control logic uses to freeze the IF/ID and EX/MEM stages.

---
 rtl/arm_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_arm_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between fetch and data. A grant in IDLE gives valid MEM_LATENCY+1 cycles later.
// The losing side stalls. Data has priority; define ARB_STARVE_GUARD_EN to force fetch to win after STARVE_LIMIT consecutive losses.
module arm_mem_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        d_req,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        d_stall,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_write_en,
  input  logic [31:0] mem_data_out
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

  if (MEM_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("arm_mem_arbiter: MEM_LATENCY and STARVE_LIMIT must both be >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [29:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        we_q, we_d;
  logic              win_d_q, win_d_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              grant;
  logic              fetch_forced;
  logic              grant_data;

  assign grant      = (state_q == IDLE) && !halted && (if_req || d_req);
  assign grant_data = d_req && !fetch_forced;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  assign fetch_forced = if_req && (starve_cnt_q == SC_MAX);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant) begin
      if (!grant_data) begin
        starve_cnt_d = '0;
      end else if (if_req && (starve_cnt_q != SC_MAX)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  assign fetch_forced = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    win_d_d    = win_d_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = ACCESS;
          lat_cnt_d = LAT_INIT;
          win_d_d   = grant_data;
          if (grant_data) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            addr_d  = if_addr;
            we_d    = 4'h0;
          end
        end
      end
      ACCESS: begin
        if (lat_cnt_q == '0) begin
          state_d = RESP;
          if (win_d_q) d_rdata_d  = mem_data_out;
          else         if_rdata_d = mem_data_out;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      win_d_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      win_d_q    <= win_d_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Byte enables fire once per access; the counter still holds its load value only in the first ACCESS cycle.
  assign mem_write_en = ((state_q == ACCESS) && (lat_cnt_q == LAT_INIT)) ? we_q : 4'h0;
  assign mem_addr     = addr_q;
  assign mem_data_in  = wdata_q;

  assign if_valid = (state_q == RESP) && !win_d_q;
  assign d_valid  = (state_q == RESP) &&  win_d_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_stall = if_req && !if_valid;
  assign d_stall  = d_req  && !d_valid;

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Scoreboarded bench for arm_mem_arbiter: directed timing scenarios followed by randomized concurrent traffic.
module tb_arm_mem_arbiter;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        rst_b, halted;
  logic        if_req, d_req;
  logic [29:0] if_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_we;
  logic        if_valid, if_stall, d_valid, d_stall;
  logic [31:0] if_rdata, d_rdata;
  logic [29:0] mem_addr;
  logic [31:0] mem_data_in, mem_data_out;
  logic [3:0]  mem_write_en;

  logic [31:0] phys    [128];
  logic [31:0] ref_mem [128];
  logic        mem_ready = 1'b0;

  logic [31:0] if_q [$];
  logic [32:0] d_q  [$];

  int cyc = 0;
  int n_checks = 0;
  int errors = 0;
  logic prev_if_req = 1'b0, prev_if_valid = 1'b0, prev_d_req = 1'b0, prev_d_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arm_mem_arbiter #(.MEM_LATENCY(ML), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_data_out(mem_data_out)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hE3A01005 : ((32'(i + 1) * 32'h9E3779B9) ^ 32'h0F0F1234);
  endfunction

  // Memory behind the arbiter: combinational read, byte-lane write on the clock edge.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 128; i++) phys[i] <= init_word(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_write_en[b]) phys[mem_addr[6:0]][8*b +: 8] <= mem_data_in[8*b +: 8];
    end
  end
  assign mem_data_out = phys[mem_addr[6:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'h0, act}, {31'h0, exp});
  endtask

  task automatic fail(input string name, input string detail);
    n_checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expectation per valid pulse.
  always @(negedge clk) begin
    logic [32:0] de;
    if (rst_b && mem_ready) begin
      chk1("if_stall", if_stall, if_req & ~if_valid);
      chk1("d_stall", d_stall, d_req & ~d_valid);
      if (if_valid && d_valid) fail("both_valid", "got both valids high, required at most one");
      if (if_valid) begin
        if (if_q.size() == 0) fail("if_valid_unexpected", "got if_valid, required none outstanding");
        else chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (d_valid) begin
        if (d_q.size() == 0) fail("d_valid_unexpected", "got d_valid, required none outstanding");
        else begin
          de = d_q.pop_front();
          if (de[32]) chk("d_rdata", d_rdata, de[31:0]);
        end
      end
      if (prev_if_req && !prev_if_valid && !if_req) fail("if_req_protocol", "got if_req dropped, required held until if_valid");
      if (prev_d_req && !prev_d_valid && !d_req) fail("d_req_protocol", "got d_req dropped, required held until d_valid");
    end
    prev_if_req   = if_req;
    prev_if_valid = if_valid;
    prev_d_req    = d_req;
    prev_d_valid  = d_valid;
  end

  // Observes n cycles starting at the issue cycle (k = 0) and releases each request after its valid.
  task automatic run_window(input int n, input int dv_at, input int iv_at, input int we_at,
                            input logic [3:0] we_exp, input logic [29:0] addr_exp);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk1("d_valid_timing", d_valid, k == dv_at);
      chk1("if_valid_timing", if_valid, k == iv_at);
      if (we_at >= 0) chk("mem_write_en", 32'(mem_write_en), (k == we_at) ? 32'(we_exp) : 32'h0);
      if (k >= 1 && k <= ML) chk("mem_addr", 32'(mem_addr), 32'(addr_exp));
      tick();
      if (k == dv_at) d_req = 1'b0;
      if (k == iv_at) if_req = 1'b0;
    end
  endtask

  task automatic wait_valid(input bit data, input string name, output int vcyc);
    vcyc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (data ? d_valid : if_valid) begin
        vcyc = cyc;
        break;
      end
    end
    if (vcyc < 0) fail(name, "got no valid pulse, required one within 200 cycles");
    tick();
  endtask

  task automatic drive_fetch(input int n);
    int t0, tv;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if_addr = 30'($urandom_range(0, 63));
      if_req  = 1'b1;
      t0      = cyc;
      if_q.push_back(ref_mem[if_addr[6:0]]);
      wait_valid(1'b0, "rand_if_timeout", tv);
      if_req = 1'b0;
      if (tv >= 0) chk1("rand_if_latency", (tv - t0) >= ML + 1, 1'b1);
    end
  endtask

  task automatic drive_data(input int n);
    int t0, tv;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      d_addr  = 30'($urandom_range(64, 119));
      d_wdata = $urandom();
      d_we    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (d_we == 4'h0) begin
        d_q.push_back({1'b1, ref_mem[d_addr[6:0]]});
      end else begin
        for (int b = 0; b < 4; b++)
          if (d_we[b]) ref_mem[d_addr[6:0]][8*b +: 8] = d_wdata[8*b +: 8];
        d_q.push_back({1'b0, 32'h0});
      end
      d_req = 1'b1;
      t0    = cyc;
      wait_valid(1'b1, "rand_d_timeout", tv);
      d_req = 1'b0;
      if (tv >= 0) chk1("rand_d_latency", (tv - t0) >= ML + 1, 1'b1);
    end
  endtask

  task automatic toggle_halt(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      halted = ($urandom_range(0, 9) == 0);
    end
    halted = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got, win;
    int          d_sent;
    logic [31:0] w;

    rst_b = 1'b0; halted = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
    repeat (3) tick();
    mem_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_d_valid", d_valid, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);
    chk("rst_mem_write_en", 32'(mem_write_en), 32'h0);
    tick();
    rst_b = 1'b1;
    tick();

    // Fetch only
    if_addr = 30'h10; if_req = 1'b1;
    if_q.push_back(32'hE3A01005);
    run_window(5, -1, ML + 1, 0, 4'h0, 30'h10);

    // Concurrent: data first, fetch granted in the following IDLE cycle
    if_addr = 30'd5; if_req = 1'b1; if_q.push_back(ref_mem[5]);
    d_addr = 30'd70; d_we = 4'h0; d_req = 1'b1; d_q.push_back({1'b1, ref_mem[70]});
    run_window(9, ML + 1, 2 * ML + 3, 0, 4'h0, 30'd70);
    chk("d_rdata_hold", d_rdata, ref_mem[70]);

    // Store with partial byte enables, then read it back
    d_addr = 30'h40; d_wdata = 32'hDEADBEEF; d_we = 4'b0011; d_req = 1'b1;
    ref_mem[64][15:0] = 16'hBEEF;
    d_q.push_back({1'b0, 32'h0});
    run_window(5, ML + 1, -1, 1, 4'b0011, 30'h40);
    d_we = 4'h0; d_req = 1'b1; d_q.push_back({1'b1, ref_mem[64]});
    run_window(5, ML + 1, -1, 0, 4'h0, 30'h40);
    w = init_word(64);
    chk("store_merge", d_rdata, {w[31:16], 16'hBEEF});

    // Halt: in-flight fetch completes, pending data is not granted
    if_addr = 30'd7; if_req = 1'b1; if_q.push_back(ref_mem[7]);
    tick();
    halted = 1'b1;
    d_addr = 30'd80; d_we = 4'h0; d_req = 1'b1; d_q.push_back({1'b1, ref_mem[80]});
    run_window(8, -1, ML, -1, 4'h0, 30'd7);
    @(negedge clk);
    chk1("halt_d_stall", d_stall, 1'b1);
    chk("halt_no_grant_addr", 32'(mem_addr), 32'd7);
    tick();
    halted = 1'b0;
    run_window(5, ML + 1, -1, 0, 4'h0, 30'd80);

    // Reset in the first cycle of a store
    d_addr = 30'd120; d_wdata = 32'h12345678; d_we = 4'hF; d_req = 1'b1;
    tick();
    rst_b = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("midrst_we_before", 32'(mem_write_en), 32'hF);
    tick();
    rst_b = 1'b1;
    @(negedge clk);
    chk("midrst_mem_write_en", 32'(mem_write_en), 32'h0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
    chk("midrst_mem_data_in", mem_data_in, 32'h0);
    chk("midrst_if_rdata", if_rdata, 32'h0);
    chk("midrst_d_rdata", d_rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk1("midrst_no_d_valid", d_valid, 1'b0);
      @(negedge clk);
    end
    tick();

    // Starvation: fetch held while data re-requests right after every d_valid
    if_addr = 30'd9; if_req = 1'b1; if_q.push_back(ref_mem[9]);
    d_addr = 30'd100; d_we = 4'h0; d_req = 1'b1; d_q.push_back({1'b1, ref_mem[100]});
    d_sent = 1;
    for (int e = 0; e < 6; e++) begin
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (if_valid || d_valid) got = 1'b1;
      end
      if (!got) begin
        fail("starve_grant", "got no valid pulse, required one within 40 cycles");
        break;
      end
      win = d_valid;
`ifdef ARB_STARVE_GUARD_EN
      chk1("starve_winner_is_data", win, e != 4);
`else
      chk1("starve_winner_is_data", win, e != 5);
`endif
      tick();
      if (win) begin
        if (d_sent < 5) begin
          d_addr = 30'(100 + d_sent);
          d_q.push_back({1'b1, ref_mem[d_addr[6:0]]});
          d_sent++;
        end else begin
          d_req = 1'b0;
        end
      end else begin
        if_req = 1'b0;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick();

    // Randomized concurrent traffic with random halts
    fork
      drive_fetch(40);
      drive_data(40);
      toggle_halt(300);
    join
    repeat (3) tick();
    chk("if_queue_drained", 32'(if_q.size()), 32'h0);
    chk("d_queue_drained", 32'(d_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
